// File: rtl/int_writeback_stage.sv
// Integer writeback stage: turns execute results into register writes,
// thread rollbacks or privileged-op traps, one registered cycle later.

package int_wb_pkg;
    localparam int THREADS_PER_CORE = 4;
    localparam int NUM_VECTOR_LANES = 16;

    typedef logic [31:0] scalar_t;
    typedef scalar_t [NUM_VECTOR_LANES-1:0] vector_t;
    typedef logic [NUM_VECTOR_LANES-1:0] vector_lane_mask_t;
    typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;
    typedef logic [$clog2(NUM_VECTOR_LANES)-1:0] subcycle_t;
    typedef logic [4:0] register_idx_t;

    typedef enum logic [2:0] {
        BRANCH_CMP,
        BRANCH_ALL,
        BRANCH_ZERO,
        BRANCH_NOT_ZERO,
        BRANCH_ALWAYS,
        BRANCH_CALL_OFFSET,
        BRANCH_CALL_REGISTER,
        BRANCH_ERET
    } branch_type_t;

    typedef struct packed {
        scalar_t       pc;
        logic          has_dest;
        register_idx_t dest_reg;
        logic          dest_vector;
        logic          is_branch;
        branch_type_t  branch_type;
        subcycle_t     last_subcycle;
    } decoded_instruction_t;
endpackage

module int_writeback_stage
    import int_wb_pkg::*;
#(
    parameter int         NUM_THREADS        = THREADS_PER_CORE,
    parameter int         LINK_REG           = 31,
    parameter logic [3:0] TRAP_PRIVILEGED_OP = 4'd3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ix_instruction_valid,
    input  decoded_instruction_t           ix_instruction,
    input  vector_t                        ix_result,
    input  vector_lane_mask_t              ix_mask_value,
    input  logic [$clog2(NUM_THREADS)-1:0] ix_thread_idx,
    input  subcycle_t                      ix_subcycle,
    input  logic                           ix_rollback_en,
    input  scalar_t                        ix_rollback_pc,
    input  logic                           ix_privileged_op_fault,
    input  logic                           ix_is_eret,
    input  scalar_t                        cr_trap_handler,
    output logic                           wb_rollback_en,
    output logic [$clog2(NUM_THREADS)-1:0] wb_rollback_thread_idx,
    output scalar_t                        wb_rollback_pc,
    output subcycle_t                      wb_rollback_subcycle,
    output logic                           wb_trap,
    output logic [3:0]                     wb_trap_cause,
    output scalar_t                        wb_trap_pc,
    output logic                           wb_writeback_en,
    output logic [$clog2(NUM_THREADS)-1:0] wb_writeback_thread_idx,
    output logic                           wb_writeback_is_vector,
    output logic [4:0]                     wb_writeback_reg,
    output vector_t                        wb_writeback_value,
    output vector_lane_mask_t              wb_writeback_mask,
    output logic                           wb_perf_instruction_retire
);

    localparam int TW = $clog2(NUM_THREADS);

    logic              accept;
    logic              redirect;
    logic              is_call;
    logic              last_sub;

    logic              rb_en_q,    rb_en_d;
    logic [TW-1:0]     tid_q,      tid_d;
    scalar_t           rb_pc_q,    rb_pc_d;
    subcycle_t         rb_sub_q,   rb_sub_d;
    logic              trap_q,     trap_d;
    logic [3:0]        cause_q,    cause_d;
    scalar_t           trap_pc_q,  trap_pc_d;
    logic              wb_en_q,    wb_en_d;
    logic              wb_vec_q,   wb_vec_d;
    logic [4:0]        wb_reg_q,   wb_reg_d;
    vector_t           wb_val_q,   wb_val_d;
    vector_lane_mask_t wb_mask_q,  wb_mask_d;
    logic              retire_q,   retire_d;

    always_comb begin
        // A rollback we just issued squashes the same thread's next result
        accept   = ix_instruction_valid
                   && !(rb_en_q && tid_q == ix_thread_idx);
        // ERET always redirects the thread
        redirect = ix_rollback_en || ix_is_eret;
        is_call  = ix_instruction.is_branch
                   && (ix_instruction.branch_type == BRANCH_CALL_OFFSET
                    || ix_instruction.branch_type == BRANCH_CALL_REGISTER);
        last_sub = ix_subcycle == ix_instruction.last_subcycle;

        rb_en_d   = 1'b0;
        tid_d     = ix_thread_idx;
        rb_pc_d   = ix_rollback_pc;
        rb_sub_d  = '0;
        trap_d    = 1'b0;
        cause_d   = TRAP_PRIVILEGED_OP;
        trap_pc_d = ix_instruction.pc;
        wb_en_d   = 1'b0;
        wb_vec_d  = ix_instruction.dest_vector;
        wb_reg_d  = ix_instruction.dest_reg;
        wb_val_d  = ix_result;
        wb_mask_d = ix_instruction.dest_vector ? ix_mask_value : '1;
        retire_d  = 1'b0;

        if (accept) begin
            if (ix_privileged_op_fault) begin
                trap_d  = 1'b1;
                rb_en_d = 1'b1;
                rb_pc_d = cr_trap_handler;
            end else if (redirect) begin
                rb_en_d  = 1'b1;
                retire_d = last_sub;
                if (is_call) begin
                    wb_en_d     = 1'b1;
                    wb_vec_d    = 1'b0;
                    wb_reg_d    = 5'(LINK_REG);
                    wb_val_d    = '0;
                    wb_val_d[0] = ix_instruction.pc + 32'd4;
                    wb_mask_d   = '1;
                end
            end else begin
                wb_en_d  = ix_instruction.has_dest;
                retire_d = last_sub;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rb_en_q   <= 1'b0;
            tid_q     <= '0;
            rb_pc_q   <= '0;
            rb_sub_q  <= '0;
            trap_q    <= 1'b0;
            cause_q   <= '0;
            trap_pc_q <= '0;
            wb_en_q   <= 1'b0;
            wb_vec_q  <= 1'b0;
            wb_reg_q  <= '0;
            wb_val_q  <= '0;
            wb_mask_q <= '0;
            retire_q  <= 1'b0;
        end else begin
            rb_en_q   <= rb_en_d;
            tid_q     <= tid_d;
            rb_pc_q   <= rb_pc_d;
            rb_sub_q  <= rb_sub_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
            trap_pc_q <= trap_pc_d;
            wb_en_q   <= wb_en_d;
            wb_vec_q  <= wb_vec_d;
            wb_reg_q  <= wb_reg_d;
            wb_val_q  <= wb_val_d;
            wb_mask_q <= wb_mask_d;
            retire_q  <= retire_d;
        end
    end

    assign wb_rollback_en             = rb_en_q;
    assign wb_rollback_thread_idx     = tid_q;
    assign wb_rollback_pc             = rb_pc_q;
    assign wb_rollback_subcycle       = rb_sub_q;
    assign wb_trap                    = trap_q;
    assign wb_trap_cause              = cause_q;
    assign wb_trap_pc                 = trap_pc_q;
    assign wb_writeback_en            = wb_en_q;
    assign wb_writeback_thread_idx    = tid_q;
    assign wb_writeback_is_vector     = wb_vec_q;
    assign wb_writeback_reg           = wb_reg_q;
    assign wb_writeback_value         = wb_val_q;
    assign wb_writeback_mask          = wb_mask_q;
    assign wb_perf_instruction_retire = retire_q;

endmodule

// File: tb/tb_int_writeback_stage.sv
// Bench for int_writeback_stage: vector table plus multi-cycle sequences,
// expectations queued at drive time and popped one cycle later.

module tb_int_writeback_stage;
    import int_wb_pkg::*;

    logic                 clk;
    logic                 reset;
    logic                 ix_instruction_valid;
    decoded_instruction_t ix_instruction;
    vector_t              ix_result;
    vector_lane_mask_t    ix_mask_value;
    local_thread_idx_t    ix_thread_idx;
    subcycle_t            ix_subcycle;
    logic                 ix_rollback_en;
    scalar_t              ix_rollback_pc;
    logic                 ix_privileged_op_fault;
    logic                 ix_is_eret;
    scalar_t              cr_trap_handler;
    logic                 wb_rollback_en;
    local_thread_idx_t    wb_rollback_thread_idx;
    scalar_t              wb_rollback_pc;
    subcycle_t            wb_rollback_subcycle;
    logic                 wb_trap;
    logic [3:0]           wb_trap_cause;
    scalar_t              wb_trap_pc;
    logic                 wb_writeback_en;
    local_thread_idx_t    wb_writeback_thread_idx;
    logic                 wb_writeback_is_vector;
    logic [4:0]           wb_writeback_reg;
    vector_t              wb_writeback_value;
    vector_lane_mask_t    wb_writeback_mask;
    logic                 wb_perf_instruction_retire;

    int_writeback_stage dut (
        .clk                        (clk),
        .reset                      (reset),
        .ix_instruction_valid       (ix_instruction_valid),
        .ix_instruction             (ix_instruction),
        .ix_result                  (ix_result),
        .ix_mask_value              (ix_mask_value),
        .ix_thread_idx              (ix_thread_idx),
        .ix_subcycle                (ix_subcycle),
        .ix_rollback_en             (ix_rollback_en),
        .ix_rollback_pc             (ix_rollback_pc),
        .ix_privileged_op_fault     (ix_privileged_op_fault),
        .ix_is_eret                 (ix_is_eret),
        .cr_trap_handler            (cr_trap_handler),
        .wb_rollback_en             (wb_rollback_en),
        .wb_rollback_thread_idx     (wb_rollback_thread_idx),
        .wb_rollback_pc             (wb_rollback_pc),
        .wb_rollback_subcycle       (wb_rollback_subcycle),
        .wb_trap                    (wb_trap),
        .wb_trap_cause              (wb_trap_cause),
        .wb_trap_pc                 (wb_trap_pc),
        .wb_writeback_en            (wb_writeback_en),
        .wb_writeback_thread_idx    (wb_writeback_thread_idx),
        .wb_writeback_is_vector     (wb_writeback_is_vector),
        .wb_writeback_reg           (wb_writeback_reg),
        .wb_writeback_value         (wb_writeback_value),
        .wb_writeback_mask          (wb_writeback_mask),
        .wb_perf_instruction_retire (wb_perf_instruction_retire)
    );

    typedef struct {
        string             name;
        logic              full;
        logic              rb_en;
        local_thread_idx_t rb_tid;
        scalar_t           rb_pc;
        logic              trap;
        logic [3:0]        cause;
        scalar_t           trap_pc;
        logic              wb_en;
        local_thread_idx_t wb_tid;
        logic              wb_vec;
        logic [4:0]        wb_reg;
        vector_t           val;
        vector_lane_mask_t mask;
        logic              retire;
    } exp_t;

    typedef struct {
        logic                 rst;
        logic                 valid;
        decoded_instruction_t ins;
        scalar_t              res0;
        vector_lane_mask_t    mask;
        local_thread_idx_t    tid;
        subcycle_t            sub;
        logic                 rb;
        scalar_t              rbpc;
        logic                 fault;
        logic                 eret;
        scalar_t              handler;
        exp_t                 e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    vec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vector_t lanes(scalar_t b);
        vector_t r;
        for (int i = 0; i < NUM_VECTOR_LANES; i++) r[i] = b + scalar_t'(i);
        return r;
    endfunction

    function automatic vec_t base(string n, local_thread_idx_t t);
        vec_t v;
        v.rst = 1'b0; v.valid = 1'b1; v.ins = '0; v.res0 = '0;
        v.mask = 16'h1234; v.tid = t; v.sub = '0; v.rb = 1'b0;
        v.rbpc = '0; v.fault = 1'b0; v.eret = 1'b0;
        v.handler = 32'h100;
        v.e.name = n; v.e.full = 1'b0; v.e.rb_en = 1'b0;
        v.e.rb_tid = t; v.e.rb_pc = '0; v.e.trap = 1'b0;
        v.e.cause = '0; v.e.trap_pc = '0; v.e.wb_en = 1'b0;
        v.e.wb_tid = t; v.e.wb_vec = 1'b0; v.e.wb_reg = '0;
        v.e.val = '0; v.e.mask = '1; v.e.retire = 1'b0;
        return v;
    endfunction

    // Reset row: every output, data included, must read zero
    function automatic vec_t rst_row(string n);
        vec_t v;
        v = base(n, 2'd0);
        v.rst = 1'b1;
        v.e.full = 1'b1;
        v.e.mask = '0;
        return v;
    endfunction

    task automatic chk(string nm, string f, logic [511:0] got,
                       logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s got=%0h exp=%0h", nm, f, got, exp);
        end
    endtask

    task automatic drive(vec_t v);
        reset                  = v.rst;
        ix_instruction_valid   = v.valid;
        ix_instruction         = v.ins;
        ix_result              = lanes(v.res0);
        ix_mask_value          = v.mask;
        ix_thread_idx          = v.tid;
        ix_subcycle            = v.sub;
        ix_rollback_en         = v.rb;
        ix_rollback_pc         = v.rbpc;
        ix_privileged_op_fault = v.fault;
        ix_is_eret             = v.eret;
        cr_trap_handler        = v.handler;
        exp_q.push_back(v.e);
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard got=empty exp=entry");
            return;
        end
        e = exp_q.pop_front();
        chk(e.name, "rb_en", 512'(wb_rollback_en), 512'(e.rb_en));
        chk(e.name, "trap", 512'(wb_trap), 512'(e.trap));
        chk(e.name, "wb_en", 512'(wb_writeback_en), 512'(e.wb_en));
        chk(e.name, "retire", 512'(wb_perf_instruction_retire),
            512'(e.retire));
        if (e.full || e.rb_en) begin
            chk(e.name, "rb_tid", 512'(wb_rollback_thread_idx),
                512'(e.rb_tid));
            chk(e.name, "rb_pc", 512'(wb_rollback_pc), 512'(e.rb_pc));
            chk(e.name, "rb_sub", 512'(wb_rollback_subcycle), 512'(0));
        end
        if (e.full || e.trap) begin
            chk(e.name, "cause", 512'(wb_trap_cause), 512'(e.cause));
            chk(e.name, "trap_pc", 512'(wb_trap_pc), 512'(e.trap_pc));
        end
        if (e.full || e.wb_en) begin
            chk(e.name, "wb_tid", 512'(wb_writeback_thread_idx),
                512'(e.wb_tid));
            chk(e.name, "wb_vec", 512'(wb_writeback_is_vector),
                512'(e.wb_vec));
            chk(e.name, "wb_reg", 512'(wb_writeback_reg), 512'(e.wb_reg));
            chk(e.name, "wb_val", wb_writeback_value, e.val);
            chk(e.name, "wb_mask", 512'(wb_writeback_mask), 512'(e.mask));
        end
    endtask

    task automatic step(vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        vec_t v;

        reset = 1'b1;
        ix_instruction_valid = 1'b0;
        ix_instruction = '0;
        ix_result = '0;
        ix_mask_value = '0;
        ix_thread_idx = '0;
        ix_subcycle = '0;
        ix_rollback_en = 1'b0;
        ix_rollback_pc = '0;
        ix_privileged_op_fault = 1'b0;
        ix_is_eret = 1'b0;
        cr_trap_handler = '0;

        tbl.push_back(rst_row("reset"));

        v = base("add_t1", 2'd1);
        v.ins.has_dest = 1'b1; v.ins.dest_reg = 5'd5; v.res0 = 32'h7;
        v.e.wb_en = 1'b1; v.e.wb_reg = 5'd5; v.e.val = lanes(32'h7);
        v.e.retire = 1'b1;
        tbl.push_back(v);

        v = base("call", 2'd0);
        v.ins.pc = 32'h1000; v.ins.is_branch = 1'b1;
        v.ins.branch_type = BRANCH_CALL_OFFSET;
        v.rb = 1'b1; v.rbpc = 32'h2000; v.res0 = 32'hdead;
        v.e.rb_en = 1'b1; v.e.rb_pc = 32'h2000;
        v.e.wb_en = 1'b1; v.e.wb_reg = 5'd31;
        v.e.val[0] = 32'h1004; v.e.retire = 1'b1;
        tbl.push_back(v);

        v = base("br_t2", 2'd2);
        v.ins.pc = 32'h1100; v.ins.is_branch = 1'b1;
        v.ins.branch_type = BRANCH_ALWAYS;
        v.rb = 1'b1; v.rbpc = 32'h1200;
        v.e.rb_en = 1'b1; v.e.rb_pc = 32'h1200; v.e.retire = 1'b1;
        tbl.push_back(v);

        v = base("squash_t2", 2'd2);
        v.ins.has_dest = 1'b1; v.ins.dest_reg = 5'd4; v.res0 = 32'h9;
        v.rb = 1'b1; v.rbpc = 32'h7777;
        tbl.push_back(v);

        v = base("br2_t2", 2'd2);
        v.ins.pc = 32'h1104; v.ins.is_branch = 1'b1;
        v.ins.branch_type = BRANCH_ZERO;
        v.rb = 1'b1; v.rbpc = 32'h1300;
        v.e.rb_en = 1'b1; v.e.rb_pc = 32'h1300; v.e.retire = 1'b1;
        tbl.push_back(v);

        v = base("other_t3", 2'd3);
        v.ins.has_dest = 1'b1; v.ins.dest_reg = 5'd7; v.res0 = 32'h55;
        v.e.wb_en = 1'b1; v.e.wb_reg = 5'd7; v.e.val = lanes(32'h55);
        v.e.retire = 1'b1;
        tbl.push_back(v);

        v = base("fault", 2'd1);
        v.ins.pc = 32'h3000; v.ins.has_dest = 1'b1; v.ins.dest_reg = 5'd3;
        v.fault = 1'b1;
        v.e.trap = 1'b1; v.e.cause = 4'd3; v.e.trap_pc = 32'h3000;
        v.e.rb_en = 1'b1; v.e.rb_pc = 32'h100;
        tbl.push_back(v);

        v = base("squash_t1", 2'd1);
        v.ins.has_dest = 1'b1; v.ins.dest_reg = 5'd6;
        tbl.push_back(v);

        v = base("idle", 2'd0);
        v.valid = 1'b0; v.ins.has_dest = 1'b1;
        tbl.push_back(v);

        v = base("br_not_taken", 2'd0);
        v.ins.is_branch = 1'b1; v.ins.branch_type = BRANCH_CMP;
        v.e.retire = 1'b1;
        tbl.push_back(v);

        v = base("eret", 2'd0);
        v.ins.is_branch = 1'b1; v.ins.branch_type = BRANCH_ERET;
        v.rb = 1'b1; v.eret = 1'b1; v.rbpc = 32'h4000;
        v.e.rb_en = 1'b1; v.e.rb_pc = 32'h4000; v.e.retire = 1'b1;
        tbl.push_back(v);

        v = base("call_wrap", 2'd3);
        v.ins.pc = 32'hFFFF_FFFC; v.ins.is_branch = 1'b1;
        v.ins.branch_type = BRANCH_CALL_REGISTER;
        v.rb = 1'b1; v.rbpc = 32'h500;
        v.e.rb_en = 1'b1; v.e.rb_pc = 32'h500;
        v.e.wb_en = 1'b1; v.e.wb_reg = 5'd31; v.e.retire = 1'b1;
        tbl.push_back(v);

        v = base("vec_op", 2'd0);
        v.ins.has_dest = 1'b1; v.ins.dest_vector = 1'b1;
        v.ins.dest_reg = 5'd2; v.mask = 16'h0F0F; v.res0 = 32'hA0;
        v.e.wb_en = 1'b1; v.e.wb_vec = 1'b1; v.e.wb_reg = 5'd2;
        v.e.mask = 16'h0F0F; v.e.val = lanes(32'hA0); v.e.retire = 1'b1;
        tbl.push_back(v);

        v = base("fault_over_rb", 2'd2);
        v.ins.pc = 32'h3100; v.fault = 1'b1;
        v.rb = 1'b1; v.rbpc = 32'h9000;
        v.e.trap = 1'b1; v.e.cause = 4'd3; v.e.trap_pc = 32'h3100;
        v.e.rb_en = 1'b1; v.e.rb_pc = 32'h100;
        tbl.push_back(v);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        for (int s = 0; s < 4; s++) begin
            v = base($sformatf("vsub%0d", s), 2'd1);
            v.ins.has_dest = 1'b1; v.ins.dest_vector = 1'b1;
            v.ins.dest_reg = 5'd9; v.ins.last_subcycle = 4'd3;
            v.sub = subcycle_t'(s); v.mask = 16'h00FF;
            v.res0 = scalar_t'(32'h100 * s);
            v.e.wb_en = 1'b1; v.e.wb_vec = 1'b1; v.e.wb_reg = 5'd9;
            v.e.mask = 16'h00FF; v.e.val = lanes(scalar_t'(32'h100 * s));
            v.e.retire = (s == 3);
            step(v);
        end

        v = rst_row("rst_call");
        v.ins.pc = 32'h1000; v.ins.is_branch = 1'b1;
        v.ins.branch_type = BRANCH_CALL_OFFSET;
        v.rb = 1'b1; v.rbpc = 32'h2000;
        step(v);

        v = base("after_rst", 2'd0);
        v.valid = 1'b0;
        step(v);

        v = base("first_post_rst", 2'd2);
        v.ins.has_dest = 1'b1; v.ins.dest_reg = 5'd12; v.res0 = 32'h42;
        v.e.wb_en = 1'b1; v.e.wb_reg = 5'd12; v.e.val = lanes(32'h42);
        v.e.retire = 1'b1;
        step(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
